// File: rtl/fetch_queue.sv
// Instruction-fetch front end: single outstanding I-cache request feeding a DEPTH-entry {pc, inst} FIFO.
// Optional macro FETCH_QUEUE_BYPASS_EN lets a response reach decode in the same cycle when the FIFO is empty.
module fetch_queue #(
   parameter int                XLEN     = 32,
   parameter int                DEPTH    = 4,
   parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0060
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         inst_read,
   output logic [XLEN-1:0]              inst_addr,
   input  logic                         inst_resp,
   input  logic [XLEN-1:0]              inst_rdata,
   input  logic                         redirect,
   input  logic [XLEN-1:0]              redirect_pc,
   input  logic                         deq_ready,
   output logic                         deq_valid,
   output logic [XLEN-1:0]              deq_inst,
   output logic [XLEN-1:0]              deq_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      SQUASH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   fetchPc_q, fetchPc_d;
   logic [XLEN-1:0]   reqAddr_q, reqAddr_d;
   logic              instRead_q, instRead_d;
   logic [PW-1:0]     rdPtr_q, rdPtr_d;
   logic [PW-1:0]     wrPtr_q, wrPtr_d;
   logic [CW-1:0]     count_q, count_d;

   logic [XLEN-1:0]   memInst [DEPTH];
   logic [XLEN-1:0]   memPc   [DEPTH];

   logic              headValid;
   logic              respTaken;
   logic              bypassTake;
   logic              enq;
   logic              pop;
   logic              spaceNext;

   assign headValid = (count_q != '0);
   assign respTaken = (state_q == REQ) && inst_resp && !redirect;
   assign pop       = headValid && deq_ready && !redirect;
   assign enq       = respTaken && !bypassTake;

   // Head of queue; with bypass an empty queue can forward the live response straight to decode
`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypassHit;
   assign bypassHit  = !headValid && respTaken;
   assign bypassTake = bypassHit && deq_ready;

   always_comb begin
      deq_valid = headValid || bypassHit;
      deq_inst  = '0;
      deq_pc    = '0;
      if (headValid) begin
         deq_inst = memInst[rdPtr_q];
         deq_pc   = memPc[rdPtr_q];
      end else if (bypassHit) begin
         deq_inst = inst_rdata;
         deq_pc   = reqAddr_q;
      end
   end
`else
   assign bypassTake = 1'b0;

   always_comb begin
      deq_valid = headValid;
      deq_inst  = '0;
      deq_pc    = '0;
      if (headValid) begin
         deq_inst = memInst[rdPtr_q];
         deq_pc   = memPc[rdPtr_q];
      end
   end
`endif

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (redirect) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (enq) wrPtr_d = wrPtr_q + PW'(1);
         if (pop) rdPtr_d = rdPtr_q + PW'(1);
         case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // A new request may only start if the slot for its response is guaranteed
   assign spaceNext = (count_d != CW'(DEPTH));

   always_comb begin
      state_d    = state_q;
      fetchPc_d  = fetchPc_q;
      reqAddr_d  = reqAddr_q;
      instRead_d = instRead_q;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               fetchPc_d = redirect_pc;
            end else if (spaceNext) begin
               state_d    = REQ;
               reqAddr_d  = fetchPc_q;
               instRead_d = 1'b1;
            end
         end
         REQ: begin
            if (redirect) begin
               fetchPc_d = redirect_pc;
               if (inst_resp) begin
                  state_d    = IDLE;
                  instRead_d = 1'b0;
               end else begin
                  state_d = SQUASH;
               end
            end else if (inst_resp) begin
               fetchPc_d = reqAddr_q + XLEN'(4);
               if (spaceNext) begin
                  reqAddr_d = reqAddr_q + XLEN'(4);
               end else begin
                  state_d    = IDLE;
                  instRead_d = 1'b0;
               end
            end
         end
         SQUASH: begin
            if (redirect) fetchPc_d = redirect_pc;
            if (inst_resp) begin
               state_d    = IDLE;
               instRead_d = 1'b0;
            end
         end
         default: begin
            state_d    = IDLE;
            instRead_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetchPc_q  <= RESET_PC;
         reqAddr_q  <= RESET_PC;
         instRead_q <= 1'b0;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetchPc_q  <= fetchPc_d;
         reqAddr_q  <= reqAddr_d;
         instRead_q <= instRead_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
      end
   end

   // Storage is never read while its slot is unoccupied, so it needs no reset
   always_ff @(posedge clk) begin
      if (enq) begin
         memInst[wrPtr_q] <= inst_rdata;
         memPc[wrPtr_q]   <= reqAddr_q;
      end
   end

   assign inst_read = instRead_q;
   assign inst_addr = reqAddr_q;
   assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0x60).
// Expectations follow FETCH_QUEUE_BYPASS_EN when the bench is built with it.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          inst_read;
   logic [31:0]   inst_addr;
   logic          inst_resp;
   logic [31:0]   inst_rdata;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          deq_ready;
   logic          deq_valid;
   logic [31:0]   deq_inst;
   logic [31:0]   deq_pc;
   logic [2:0]    count;

   int testsRun;
   int testsFailed;

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0060)) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_read   (inst_read),
      .inst_addr   (inst_addr),
      .inst_resp   (inst_resp),
      .inst_rdata  (inst_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .deq_ready   (deq_ready),
      .deq_valid   (deq_valid),
      .deq_inst    (deq_inst),
      .deq_pc      (deq_pc),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic resp, input logic [31:0] rdata,
                                input logic redir, input logic [31:0] rpc,
                                input logic ready);
      inst_resp   = resp;
      inst_rdata  = rdata;
      redirect    = redir;
      redirect_pc = rpc;
      deq_ready   = ready;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Hold the inputs through one rising edge, then return them to quiet before sampling
   task automatic cycle(input logic resp, input logic [31:0] rdata,
                        input logic redir, input logic [31:0] rpc,
                        input logic ready);
      applyStimulus(resp, rdata, redir, rpc, ready);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_read",  32'(inst_read), 32'h0);
      checkOutput("rst_addr",  inst_addr,      32'h60);
      checkOutput("rst_valid", 32'(deq_valid), 32'h0);
      checkOutput("rst_inst",  deq_inst,       32'h0);
      checkOutput("rst_pc",    deq_pc,         32'h0);
      checkOutput("rst_count", 32'(count),     32'h0);

      rst = 1'b0;
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("first_read", 32'(inst_read), 32'h1);
      checkOutput("first_addr", inst_addr,      32'h60);

      applyStimulus(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("first_comb_valid", 32'(deq_valid), BYP ? 32'h1 : 32'h0);
      cycle(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
      checkOutput("first_valid", 32'(deq_valid), 32'h1);
      checkOutput("first_pc",    deq_pc,         32'h60);
      checkOutput("first_inst",  deq_inst,       32'h0000_0013);
      checkOutput("first_next",  inst_addr,      32'h64);

      cycle(1'b1, 32'hA000_0064, 1'b0, 32'h0, 1'b0);
      checkOutput("fill2_count", 32'(count), 32'h2);
      cycle(1'b1, 32'hA000_0068, 1'b0, 32'h0, 1'b0);
      checkOutput("fill3_count", 32'(count), 32'h3);
      checkOutput("fill3_addr",  inst_addr,  32'h6C);
      cycle(1'b1, 32'hA000_006C, 1'b0, 32'h0, 1'b0);
      checkOutput("full_count", 32'(count),     32'h4);
      checkOutput("full_read",  32'(inst_read), 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("full_hold_read", 32'(inst_read), 32'h0);
      checkOutput("full_head_pc",   deq_pc,         32'h60);

      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("pop_count",  32'(count),     32'h3);
      checkOutput("pop_read",   32'(inst_read), 32'h1);
      checkOutput("pop_addr",   inst_addr,      32'h70);
      checkOutput("pop_head",   deq_pc,         32'h64);
      checkOutput("pop_inst",   deq_inst,       32'hA000_0064);

      cycle(1'b1, 32'hA000_0070, 1'b0, 32'h0, 1'b1);
      checkOutput("ss1_count", 32'(count), 32'h3);
      checkOutput("ss1_pc",    deq_pc,     32'h68);
      cycle(1'b1, 32'hA000_0074, 1'b0, 32'h0, 1'b1);
      checkOutput("ss2_count", 32'(count), 32'h3);
      checkOutput("ss2_pc",    deq_pc,     32'h6C);
      cycle(1'b1, 32'hA000_0078, 1'b0, 32'h0, 1'b1);
      checkOutput("ss3_count", 32'(count), 32'h3);
      checkOutput("ss3_pc",    deq_pc,     32'h70);
      checkOutput("ss3_inst",  deq_inst,   32'hA000_0070);
      checkOutput("ss3_addr",  inst_addr,  32'h7C);

      cycle(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
      checkOutput("sq_count", 32'(count),     32'h0);
      checkOutput("sq_valid", 32'(deq_valid), 32'h0);
      checkOutput("sq_read",  32'(inst_read), 32'h1);
      checkOutput("sq_addr",  inst_addr,      32'h7C);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("sq_hold_addr", inst_addr, 32'h7C);
      cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
      checkOutput("sq_done_read",  32'(inst_read), 32'h0);
      checkOutput("sq_done_count", 32'(count),     32'h0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("redir_addr", inst_addr,      32'h200);
      checkOutput("redir_read", 32'(inst_read), 32'h1);

      applyStimulus(1'b1, 32'hCAFE_F00D, 1'b1, 32'h300, 1'b1);
      #1;
      checkOutput("coinc_comb_valid", 32'(deq_valid), 32'h0);
      cycle(1'b1, 32'hCAFE_F00D, 1'b1, 32'h300, 1'b1);
      checkOutput("coinc_read",  32'(inst_read), 32'h0);
      checkOutput("coinc_count", 32'(count),     32'h0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("coinc_addr", inst_addr, 32'h300);

      cycle(1'b1, 32'h1234_5678, 1'b1, 32'hFFFF_FFFC, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("wrap_req", inst_addr, 32'hFFFF_FFFC);
      cycle(1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
      checkOutput("wrap_count", 32'(count), 32'h1);
      checkOutput("wrap_pc",    deq_pc,     32'hFFFF_FFFC);
      checkOutput("wrap_next",  inst_addr,  32'h0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput("drain_count", 32'(count),     32'h0);
      checkOutput("drain_valid", 32'(deq_valid), 32'h0);
      checkOutput("drain_inst",  deq_inst,       32'h0);

      applyStimulus(1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("byp_valid", 32'(deq_valid), BYP ? 32'h1 : 32'h0);
      checkOutput("byp_inst",  deq_inst,       BYP ? 32'h2222_2222 : 32'h0);
      cycle(1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
      checkOutput("byp_count",      32'(count),     BYP ? 32'h0 : 32'h1);
      checkOutput("byp_late_valid", 32'(deq_valid), BYP ? 32'h0 : 32'h1);
      checkOutput("byp_next_addr",  inst_addr,      32'h4);

      rst = 1'b1;
      #1;
      checkOutput("midreq_rst_read",  32'(inst_read), 32'h0);
      checkOutput("midreq_rst_addr",  inst_addr,      32'h60);
      checkOutput("midreq_rst_count", 32'(count),     32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
